fifo_rd_ctrl: RTL
=================

Name: fifo_rd_ctrl

Overview:
- Read-side controller for the team's 8-deep × 4-bit FIFO; the counterpart of the write path that fills the storage registers.
- Tracks the read pointer and data count, and registers the word selected from storage onto `dout`.
- Issues a one-cycle read acknowledge or read-error status.
- Sits between the FIFO storage array and the consumer; the write side notifies it of each committed write.

Parameters:
- DATA_W, 4, width of one FIFO word
- DEPTH, 8, number of storage entries (power of two)
- PTR_W, 3, read pointer width, log2(DEPTH)
- CNT_W, 4, data count width, log2(DEPTH)+1

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- rd_en  input  1  read request, sampled each rising edge
- wr_done  input  1  one-cycle pulse from write side: one word committed to storage this cycle
- mem_flat  input  DEPTH*DATA_W  storage contents, entry i at bits [i*DATA_W +: DATA_W]
- dout  output  DATA_W  registered read data
- rd_ptr  output  PTR_W  index of next entry to read
- data_count  output  CNT_W  words currently held, 0..DEPTH
- empty  output  1  data_count == 0 (combinational from count register)
- full  output  1  data_count == DEPTH (combinational from count register)
- rd_ack  output  1  registered; 1 for the cycle after a successful read
- rd_err  output  1  registered; 1 for the cycle after a read request on empty

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately):
  - Sets dout=0, rd_ptr=0, data_count=0, rd_ack=0, rd_err=0, state=IDLE; empty=1, full=0.
  - Reset asserted mid-operation discards any in-progress read; no ack or err is emitted after release until a new rd_en.
- FSM states: IDLE, READ, RD_ERROR. The next state is evaluated every edge from rd_en and the pre-edge data_count:
  - rd_en=1, data_count>0: go to READ.
  - rd_en=1, data_count==0: go to RD_ERROR.
  - rd_en=0: go to IDLE.
  - Back-to-back reads are legal: READ→READ sustains 1 word/cycle.
- Outputs are registered per the entered state:
  - READ: rd_ack=1, rd_err=0.
  - RD_ERROR: rd_ack=0, rd_err=1.
  - IDLE: both 0.
- Read action, on the edge where rd_en=1 and data_count>0:
  - dout <= mem_flat entry[rd_ptr].
  - rd_ptr <= rd_ptr+1, wrapping DEPTH-1 → 0.
- Latency: rd_en high before edge N gives dout, rd_ack and the new rd_ptr valid after edge N (1 cycle).
- dout holds its last value in IDLE and RD_ERROR; it is never cleared except by reset.
- data_count update per edge (rd_ok = rd_en && data_count>0):
  - wr_done && !rd_ok: +1, saturating at DEPTH. wr_done while full is ignored; the write side owns that error.
  - rd_ok && !wr_done: −1.
  - rd_ok && wr_done: unchanged.
  - rd_en with data_count==0 and wr_done in the same cycle: the read errors (no write-to-read bypass), and data_count becomes 1.
- Arithmetic:
  - rd_ptr is modulo DEPTH.
  - data_count is an unsigned CNT_W value and never exceeds DEPTH or goes below 0.
- mem_flat is treated as stable; the entry at rd_ptr must have been written at least one edge before the wr_done that counted it.

Decomposition:
- Shared package fifo_pkg holds:
  - DATA_W, DEPTH, PTR_W, CNT_W constants.
  - rd_state_t enum: IDLE=2'b00, READ=2'b01, RD_ERROR=2'b10.
- Sub-module fifo_rd_mux: DEPTH:1 mux of DATA_W-bit words, select rd_ptr, purely combinational, reusable by a later write-side checker.
- Counter, pointer, FSM and output registers stay in fifo_rd_ctrl.

Test Plan:
- Reset, then idle 3 cycles → dout=0, rd_ptr=0, data_count=0, empty=1, full=0, rd_ack=0, rd_err=0.
- Preload mem entries 0..7 = 4'h1..4'h8, pulse wr_done 8 cycles → full=1, count=8; 8 consecutive rd_en → dout 1,2,…,8 one per cycle, rd_ack=1 each cycle, rd_ptr 1..7 then 0, empty=1.
- rd_en on empty (count=0) → rd_err=1 for one cycle, rd_ack=0, dout and rd_ptr unchanged; rd_en held 2 cycles → rd_err=1 both cycles.
- count=3, rd_en and wr_done together for 4 cycles → count stays 3, rd_ack=1 each cycle, rd_ptr advances by 4 mod 8; count=0 with rd_en+wr_done → rd_err=1, count=1.
- count=8, extra wr_done → count stays 8, full=1; then read 8 words while rd_ptr starts at 6 → wrap 7→0 observed, data order preserved.
- Assert reset asynchronously mid-burst (between edges, count=5, rd_ptr=4) → outputs return to reset values before the next edge; first rd_en after release → rd_err=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and types for the 8-deep x 4-bit FIFO read path.
package fifo_pkg;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 8;
    localparam int PTR_W  = 3;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        READ     = 2'b01,
        RD_ERROR = 2'b10
    } rd_state_t;

endpackage

// File: rtl/fifo_rd_mux.sv
// DEPTH:1 word selector over the flattened storage array; purely combinational.
module fifo_rd_mux #(
    parameter int DATA_W = fifo_pkg::DATA_W,
    parameter int DEPTH  = fifo_pkg::DEPTH,
    parameter int PTR_W  = fifo_pkg::PTR_W
) (
    input  logic [DEPTH*DATA_W-1:0] mem_flat_i,
    input  logic [PTR_W-1:0]        sel_i,
    output logic [DATA_W-1:0]       word_o
);

    always_comb begin
        word_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_i == PTR_W'(i)) begin
                word_o = mem_flat_i[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: read pointer, occupancy count, registered read data
// and one-cycle acknowledge / error status.
module fifo_rd_ctrl
    import fifo_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rd_en,
    input  logic                    wr_done,
    input  logic [DEPTH*DATA_W-1:0] mem_flat,
    output logic [DATA_W-1:0]       dout,
    output logic [PTR_W-1:0]        rd_ptr,
    output logic [CNT_W-1:0]        data_count,
    output logic                    empty,
    output logic                    full,
    output logic                    rd_ack,
    output logic                    rd_err
);

    rd_state_t         state_q, state_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] rd_word;
    logic              rd_ok;

    assign rd_ok = rd_en && (count_q != '0);

    fifo_rd_mux #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_rd_mux (
        .mem_flat_i (mem_flat),
        .sel_i      (rd_ptr_q),
        .word_o     (rd_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (rd_en) begin
            state_d = (count_q != '0) ? READ : RD_ERROR;
        end
    end

    // Status outputs decode the state register, so they are registered by construction.
    always_comb begin
        rd_ack = 1'b0;
        rd_err = 1'b0;
        unique case (state_q)
            READ:     rd_ack = 1'b1;
            RD_ERROR: rd_err = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            dout_d   = rd_word;
        end
    end

    // A write while full is dropped here; the write side reports that overflow.
    always_comb begin
        count_d = count_q;
        if (wr_done && !rd_ok) begin
            if (count_q != CNT_W'(DEPTH)) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (rd_ok && !wr_done) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    assign dout       = dout_q;
    assign rd_ptr     = rd_ptr_q;
    assign data_count = count_q;
    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));

endmodule
